// File: rtl/frost32_mem_responder.sv
// Memory-side responder for the Frost32 CPU data port: word RAM with wait states,
// little-endian 32/16/8-bit lane steering and access-error reporting.
module frost32_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1,
   parameter int IRQ_ON_ERR  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_mem_access,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   input  logic        data_inout_access_type,
   input  logic [1:0]  data_inout_access_size,
   output logic [31:0] data_out,
   output logic        wait_for_mem,
   output logic        interrupt,
   input  logic        irq_ack,
   output logic        err_sticky,
   input  logic        err_clr
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic [31:0] lat_addr, lat_data;
   logic        lat_type;
   logic [1:0]  lat_size;
   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0]   acc_addr, acc_data;
   logic          acc_type;
   logic [1:0]    acc_size;
   logic [AW-1:0] widx;
   logic          acc_err;
   logic [31:0]   rword, rdata, wword;
   logic          commit;

   // With zero wait states the commit edge is the request edge itself, so the
   // live inputs are used in IDLE and the latched copy everywhere else.
   always_comb begin
      acc_addr = lat_addr;
      acc_data = lat_data;
      acc_type = lat_type;
      acc_size = lat_size;
      if (state == IDLE) begin
         acc_addr = addr;
         acc_data = data_in;
         acc_type = data_inout_access_type;
         acc_size = data_inout_access_size;
      end
   end

   assign widx  = acc_addr[AW+1:2];
   assign rword = mem[widx];

   always_comb begin
      acc_err = 1'b0;
      if (acc_size == 2'd3)                              acc_err = 1'b1;
      if (acc_size == 2'd0 && acc_addr[1:0] != 2'b00)    acc_err = 1'b1;
      if (acc_size == 2'd1 && acc_addr[0])               acc_err = 1'b1;
      if ((acc_addr >> (AW + 2)) != '0)                  acc_err = 1'b1;
   end

   always_comb begin
      rdata = '0;
      wword = rword;
      case (acc_size)
         2'd0: begin
            rdata = rword;
            wword = acc_data;
         end
         2'd1: begin
            if (acc_addr[1]) begin
               rdata[15:0]  = rword[31:16];
               wword[31:16] = acc_data[15:0];
            end else begin
               rdata[15:0]  = rword[15:0];
               wword[15:0]  = acc_data[15:0];
            end
         end
         2'd2: begin
            rdata[7:0] = rword[{acc_addr[1:0], 3'b000} +: 8];
            wword[{acc_addr[1:0], 3'b000} +: 8] = acc_data[7:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      wait_for_mem = 1'b0;
      commit       = 1'b0;
      case (state)
         IDLE: begin
            wait_for_mem = req_mem_access;
            if (req_mem_access) begin
               if (WAIT_STATES == 0) begin
                  state_nx = DONE;
                  commit   = 1'b1;
               end else begin
                  state_nx = BUSY;
                  cnt_nx   = 4'(WAIT_STATES - 1);
               end
            end
         end
         BUSY: begin
            wait_for_mem = 1'b1;
            if (cnt == '0) begin
               state_nx = DONE;
               commit   = 1'b1;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         lat_addr   <= '0;
         lat_data   <= '0;
         lat_type   <= 1'b0;
         lat_size   <= '0;
         data_out   <= '0;
         interrupt  <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (state == IDLE && req_mem_access) begin
            lat_addr <= addr;
            lat_data <= data_in;
            lat_type <= data_inout_access_type;
            lat_size <= data_inout_access_size;
         end
         if (commit) begin
            if (acc_err)        data_out <= '0;
            else if (!acc_type) data_out <= rdata;
         end
         if (commit && acc_err)     err_sticky <= 1'b1;
         else if (err_clr)          err_sticky <= 1'b0;
         if (commit && acc_err && IRQ_ON_ERR != 0) interrupt <= 1'b1;
         else if (irq_ack)                         interrupt <= 1'b0;
      end
   end

   // RAM is not reset; the rst_n gate keeps a reset-time IDLE request from writing.
   always_ff @(posedge clk) begin
      if (rst_n && commit && acc_type && !acc_err)
         mem[widx] <= wword;
   end

endmodule

// File: tb/tb_frost32_mem_responder.sv
// Scoreboard bench: three responders (1, 0 and 4 wait states) checked against a
// byte-addressed reference memory with a decoupled completion monitor.
module tb_frost32_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n [3];
   logic        req   [3];
   logic        atype [3];
   logic        err_clr [3];
   logic        irq_ack [3];
   logic        wt    [3];
   logic        irq   [3];
   logic        sticky [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [31:0] dout  [3];
   logic [1:0]  asize [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      frost32_mem_responder #(
         .DEPTH_WORDS(1024),
         .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 4)),
         .IRQ_ON_ERR(1)
      ) u_dut (
         .clk(clk),
         .rst_n(rst_n[g]),
         .req_mem_access(req[g]),
         .addr(addr[g]),
         .data_in(wdata[g]),
         .data_inout_access_type(atype[g]),
         .data_inout_access_size(asize[g]),
         .data_out(dout[g]),
         .wait_for_mem(wt[g]),
         .interrupt(irq[g]),
         .irq_ack(irq_ack[g]),
         .err_sticky(sticky[g]),
         .err_clr(err_clr[g])
      );
   end

   typedef struct {
      int          k;
      logic [31:0] dout;
      logic        st;
      logic        iq;
      int          waits;
   } exp_t;

   // Reference model: memory as plain bytes, plus the externally visible status.
   logic [7:0]  mb [3][4096];
   logic [31:0] last_dout [3];
   logic        m_sticky [3];
   logic        m_irq [3];
   int          ws_of [3] = '{1, 0, 4};

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Completion monitor: a DONE cycle is the first low wait_for_mem after a high run.
   int   prev [3] = '{0, 0, 0};
   int   wc   [3] = '{0, 0, 0};
   exp_t mon_e;
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n[k]) begin
            prev[k] = 0;
            wc[k]   = 0;
         end else if (wt[k]) begin
            wc[k]++;
            prev[k] = 1;
         end else if (prev[k] != 0) begin
            prev[k] = 0;
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done inst=%0d actual=done required=none", k);
            end else begin
               mon_e = sbq.pop_front();
               chk("inst", k, mon_e.k);
               chk("data_out", dout[k], mon_e.dout);
               chk("err_sticky", sticky[k], mon_e.st);
               chk("interrupt", irq[k], mon_e.iq);
               chk("wait_cycles", wc[k], mon_e.waits);
            end
            wc[k] = 0;
         end
      end
   end

   task automatic access(int k, bit wr, logic [1:0] sz, logic [31:0] a,
                         logic [31:0] d, bit clr);
      exp_t        e;
      bit          er;
      logic [31:0] rv;
      int          nb;
      int          n;
      er = (sz == 2'd3) || (sz == 2'd0 && a[1:0] != 2'b00) ||
           (sz == 2'd1 && a[0]) || (a >= 32'd4096);
      nb = (sz == 2'd0) ? 4 : ((sz == 2'd1) ? 2 : 1);
      rv = '0;
      if (!er) begin
         for (int i = 0; i < nb; i++) begin
            if (wr) mb[k][int'(a) + i] = d[8*i +: 8];
            else    rv[8*i +: 8] = mb[k][int'(a) + i];
         end
      end
      if (clr) begin
         m_sticky[k] = 1'b0;
         m_irq[k]    = 1'b0;
      end
      if (er) begin
         last_dout[k] = '0;
         m_sticky[k]  = 1'b1;
         m_irq[k]     = 1'b1;
      end else if (!wr) begin
         last_dout[k] = rv;
      end
      e = '{k, last_dout[k], m_sticky[k], m_irq[k], ws_of[k] + 1};
      sbq.push_back(e);

      req[k] = 1'b1; atype[k] = wr; asize[k] = sz; addr[k] = a; wdata[k] = d;
      err_clr[k] = clr; irq_ack[k] = clr;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (wt[k] && n < 40);
      if (wt[k]) begin
         total++;
         bad++;
         $display("FAIL timeout inst=%0d actual=busy required=done", k);
      end
      req[k] = 1'b0; err_clr[k] = 1'b0; irq_ack[k] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic pulse(int k, bit c, bit ack);
      err_clr[k] = c; irq_ack[k] = ack;
      @(posedge clk); #1;
      err_clr[k] = 1'b0; irq_ack[k] = 1'b0;
      if (c)   m_sticky[k] = 1'b0;
      if (ack) m_irq[k]    = 1'b0;
      chk("pulse_sticky", sticky[k], m_sticky[k]);
      chk("pulse_irq", irq[k], m_irq[k]);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      for (int k = 0; k < 3; k++) begin
         rst_n[k] = 1'b0; req[k] = 1'b0; atype[k] = 1'b0; asize[k] = '0;
         addr[k] = '0; wdata[k] = '0; err_clr[k] = 1'b0; irq_ack[k] = 1'b0;
         last_dout[k] = '0; m_sticky[k] = 1'b0; m_irq[k] = 1'b0;
      end
      #12;
      for (int k = 0; k < 3; k++) begin
         chk("rst_data_out", dout[k], 32'h0);
         chk("rst_wait", wt[k], 1'b0);
         chk("rst_irq", irq[k], 1'b0);
         chk("rst_sticky", sticky[k], 1'b0);
      end
      @(negedge clk); #2;
      for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
      @(posedge clk); #1;

      // One wait state: basic word access and lane steering
      access(0, 1, 2'd0, 32'h10, 32'hDEADBEEF, 0);
      access(0, 0, 2'd0, 32'h10, 32'h0, 0);
      access(0, 1, 2'd0, 32'h10, 32'h11223344, 0);
      access(0, 1, 2'd2, 32'h13, 32'h000000AA, 0);
      access(0, 0, 2'd0, 32'h10, 32'h0, 0);
      access(0, 0, 2'd1, 32'h12, 32'h0, 0);
      access(0, 0, 2'd2, 32'h11, 32'h0, 0);

      // Error responses and their clears
      access(0, 1, 2'd0, 32'h0, 32'h5A5A0F0F, 0);
      access(0, 0, 2'd0, 32'h02, 32'h0, 0);
      access(0, 0, 2'd0, 32'h0, 32'h0, 0);
      pulse(0, 0, 1);
      pulse(0, 1, 0);
      access(0, 0, 2'd3, 32'h10, 32'h0, 0);
      pulse(0, 1, 1);
      access(0, 0, 2'd0, 32'h1000, 32'h0, 0);
      pulse(0, 1, 1);
      access(0, 1, 2'd1, 32'h11, 32'hFFFF, 0);
      pulse(0, 1, 1);
      access(0, 0, 2'd3, 32'h4, 32'h0, 1);
      access(0, 1, 2'd0, 32'h14, 32'h0BADF00D, 1);

      // Randomized traffic over a preloaded 256-byte window
      for (int w = 0; w < 64; w++) access(0, 1, 2'd0, 32'(w * 4), $urandom, 0);
      for (int i = 0; i < 150; i++) begin
         a  = 32'($urandom_range(0, 255));
         sz = ($urandom_range(0, 7) == 7) ? 2'd3 : 2'($urandom_range(0, 2));
         if ($urandom_range(0, 7) != 0) begin
            if (sz == 2'd0) a[1:0] = 2'b00;
            if (sz == 2'd1) a[0]   = 1'b0;
         end
         if ($urandom_range(0, 15) == 0) a = a | 32'h1000;
         access(0, 1'($urandom_range(0, 1)), sz, a, $urandom, 0);
         if ($urandom_range(0, 9) == 0) pulse(0, 1, 1);
      end

      // Zero wait states: back-to-back reads
      access(1, 1, 2'd0, 32'h0, 32'h01020304, 0);
      access(1, 1, 2'd0, 32'h4, 32'hA0B0C0D0, 0);
      access(1, 0, 2'd0, 32'h0, 32'h0, 0);
      access(1, 0, 2'd0, 32'h4, 32'h0, 0);
      for (int i = 0; i < 30; i++) begin
         sz = 2'($urandom_range(0, 2));
         a  = 32'($urandom_range(0, 7));
         if (sz == 2'd0) a[1:0] = 2'b00;
         if (sz == 2'd1) a[0]   = 1'b0;
         access(1, 1'($urandom_range(0, 1)), sz, a, $urandom, 0);
      end

      // Four wait states: reset abandons an in-flight write
      access(2, 1, 2'd0, 32'h20, 32'hCAFEF00D, 0);
      access(2, 0, 2'd0, 32'h2000, 32'h0, 0);
      access(2, 0, 2'd0, 32'h20, 32'h0, 0);
      req[2] = 1'b1; atype[2] = 1'b1; asize[2] = 2'd0;
      addr[2] = 32'h20; wdata[2] = 32'h12345678;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_n[2] = 1'b0; req[2] = 1'b0;
      #1;
      m_sticky[2] = 1'b0; m_irq[2] = 1'b0; last_dout[2] = '0;
      chk("abort_data_out", dout[2], 32'h0);
      chk("abort_wait", wt[2], 1'b0);
      chk("abort_irq", irq[2], m_irq[2]);
      chk("abort_sticky", sticky[2], m_sticky[2]);
      @(negedge clk); #2;
      rst_n[2] = 1'b1;
      @(posedge clk); #1;
      access(2, 0, 2'd0, 32'h20, 32'h0, 0);
      for (int i = 0; i < 10; i++) access(2, 0, 2'd2, 32'(32 + (i % 4)), 32'h0, 0);

      repeat (4) @(posedge clk);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/frost32_mem_responder.md
Name: frost32_mem_responder

Overview:
- Memory-side responder for the Frost32 CPU data port.
- Accepts the CPU's outbound memory-access request: data, addr, access type, access size, req_mem_access.
- Returns inbound data, wait_for_mem and interrupt to the CPU.
- Backs requests with an internal word-organised RAM, inserts configurable wait states, and handles 32/16/8-bit little-endian lane steering and access-error detection.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit RAM words; power of two.
- WAIT_STATES, 1: extra busy cycles per access; 0..15.
- IRQ_ON_ERR, 1: when 1, an access error raises interrupt.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_mem_access  in  1  CPU request strobe.
- addr  in  32  byte address.
- data_in  in  32  CPU write data; lane-aligned at bit 0 for 16/8-bit.
- data_inout_access_type  in  1  0=DiatRead, 1=DiatWrite.
- data_inout_access_size  in  2  0=Dias32, 1=Dias16, 2=Dias8, 3=DiasBad.
- data_out  out  32  read data to CPU; zero-extended for 16/8-bit.
- wait_for_mem  out  1  CPU must stall and hold the request while high.
- interrupt  out  1  error interrupt to CPU.
- irq_ack  in  1  clears interrupt.
- err_sticky  out  1  set on any access error.
- err_clr  in  1  clears err_sticky.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, data_out=0, interrupt=0, err_sticky=0, wait counter=0.
  - RAM contents are not cleared.
- States: IDLE, BUSY, DONE.
- IDLE:
  - wait_for_mem = req_mem_access (combinational), so the CPU stalls in the request cycle.
  - On req=1, latch addr, data_in, type and size.
  - Next state is BUSY with counter=WAIT_STATES-1, or DONE if WAIT_STATES=0.
- BUSY:
  - wait_for_mem=1.
  - Counter decrements each cycle; at 0, go to DONE.
  - Request inputs are ignored here; the latched copy is authoritative.
- Commit edge = the edge entering DONE. On this edge:
  - The write is committed, or the read data is registered into data_out.
- DONE:
  - wait_for_mem=0 and data_out is valid; the CPU consumes data this cycle.
  - Next state is always IDLE. req in DONE is ignored; the CPU must deassert it or re-present it in the following IDLE cycle.
- Latency: request seen in cycle T gives wait_for_mem high for T..T+WAIT_STATES and data valid at T+WAIT_STATES+1.
- data_out holds its value until the next commit edge. Writes do not change data_out.
- Word index = addr[log2(DEPTH_WORDS)+1:2].
- Lane selection, little-endian:
  - Dias16: half = addr[1]; bytes {1,0} or {3,2}.
  - Dias8: byte = addr[1:0].
- Reads zero-extend into data_out[31:0].
- Writes modify only the selected bytes, taken from data_in[15:0] or data_in[7:0].
- Error conditions:
  - size=DiasBad.
  - Dias32 with addr[1:0]!=0.
  - Dias16 with addr[0]!=0.
  - addr[31:log2(DEPTH_WORDS)+2] != 0.
- On error:
  - Full wait-state timing is still observed.
  - No RAM write; data_out=0 at the commit edge.
  - err_sticky is set.
  - If IRQ_ON_ERR=1, interrupt is set.
- Clear priority:
  - err_clr and a new error on the same edge: set wins.
  - irq_ack and a new error on the same edge: set wins.
- Reset mid-BUSY: the access is abandoned with no RAM write, and the state returns to IDLE.

Test Plan:
- WAIT_STATES=1:
  - Write 32-bit 0xDEADBEEF to 0x10: wait_for_mem high 2 cycles, low on the 3rd.
  - Then read 0x10: data_out=0xDEADBEEF at T+2.
- Byte/half lanes:
  - Write 8-bit 0xAA to 0x13 over word 0x11223344: word becomes 0xAA223344.
  - Read 16-bit at 0x12: 0x0000AA22.
  - Read 8-bit at 0x11: 0x00000033.
- Errors:
  - Read Dias32 at 0x02: data_out=0, err_sticky=1, interrupt=1, RAM unchanged.
  - irq_ack pulse: interrupt=0.
  - err_clr pulse: err_sticky=0.
  - Repeat with DiasBad and with addr 0x0000_1000 (DEPTH_WORDS=1024): same response.
- WAIT_STATES=0: back-to-back reads of 0x0 and 0x4 (req re-asserted in the IDLE after DONE).
  - wait_for_mem high exactly 1 cycle per access.
  - Data valid the following cycle.
- Reset mid-BUSY (WAIT_STATES=4): assert rst_n=0 during a write of 0x12345678 to 0x20.
  - Outputs go to reset values asynchronously.
  - A subsequent read of 0x20 returns the prior contents.
- Same-edge priority: error commit coincident with err_clr=1 and irq_ack=1 -> err_sticky=1 and interrupt=1 after the edge.
